// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM states, matrix geometry and key-code lookup for the keypad scanner
package keypad_pkg;
    typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_e;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    // Indexed by {row, col}; entry 15 (row 3, col 3) is listed first.
    localparam logic [15:0][3:0] KEY_MAP = '{
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };
    function automatic logic [3:0] code_of(input logic [1:0] row, input logic [1:0] col);
        return KEY_MAP[{row, col}];
    endfunction
endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad pins plus the key interface handed to the game-control logic
interface keypad_scanner_if;
    logic [3:0] rowN;
    logic [3:0] colN;
    logic [3:0] keyPad;
    logic       keyPadValid;
    logic       keyIsPressed;
    modport master (input rowN, output colN, keyPad, keyPadValid, keyIsPressed);
    modport slave  (output rowN, input colN, keyPad, keyPadValid, keyIsPressed);
endinterface

// File: rtl/keypad_sync.sv
// keypad_sync: two-flop synchroniser for the asynchronous keypad rows, idles at all-ones (no key)
module keypad_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] meta_q, sync_q;
    // Two register stages to resolve metastability before any decision uses the rows.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end
    assign q_o = sync_q;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low keypad scan, debounce and hex encode; KEYPAD_AUTOREPEAT_EN adds held-key repeat pulses
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 25000,
    parameter int DEBOUNCE_SCANS = 20,
    parameter int REPEAT_TICKS   = 250
) (
    input logic        clk,
    input logic        resetN,
    keypad_scanner_if.master kp
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

    if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 2 || REPEAT_TICKS < 1) begin : g_bad_params
        $error("keypad_scanner: illegal parameters");
    end

    logic [3:0]    rs;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    col_q, row_q, low_row;
    logic [DW-1:0] deb_q;
    logic [3:0]    key_q;
    logic          valid_q, pressed_q;
    state_e        state_q;
    logic          sample, any_low, same_row, cand_low, deb_last, rep_fire;

    keypad_sync #(.WIDTH(NUM_ROWS)) u_sync (
        .clk    (clk),
        .resetN (resetN),
        .d_i    (kp.rowN),
        .q_o    (rs)
    );

    assign sample   = cnt_q == CW'(SCAN_DIV - 1);
    assign cnt_d    = sample ? '0 : cnt_q + 1'b1;
    assign any_low  = rs != 4'hF;
    assign low_row  = !rs[0] ? 2'd0 : !rs[1] ? 2'd1 : !rs[2] ? 2'd2 : 2'd3;
    assign same_row = any_low && low_row == row_q;
    assign cand_low = !rs[row_q];
    assign deb_last = deb_q == DW'(DEBOUNCE_SCANS - 1);

    // Column slot timer; the last count of each slot is the sample instant.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_TICKS + 1);
    logic [RW-1:0] rep_q, rep_d;
    logic          rep_last;
    assign rep_last = rep_q == RW'(REPEAT_TICKS - 1);
    assign rep_fire = state_q == HELD && sample && cand_low && rep_last;
    assign rep_d    = state_q != HELD ? '0 : (sample && cand_low) ? (rep_last ? '0 : rep_q + 1'b1) : rep_q;
    // Counts held samples; idles at zero outside HELD so every hold starts a fresh period.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) rep_q <= '0;
        else         rep_q <= rep_d;
    end
`else
    assign rep_fire = 1'b0;
`endif

    // Scan/debounce FSM; the column is frozen while a candidate key is being tracked.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= SCAN;
            col_q     <= '0;
            row_q     <= '0;
            deb_q     <= '0;
            key_q     <= '0;
            valid_q   <= 1'b0;
            pressed_q <= 1'b0;
        end else begin
            valid_q <= rep_fire;
            if (sample) begin
                case (state_q)
                    SCAN: begin
                        if (any_low) begin
                            row_q   <= low_row;
                            deb_q   <= DW'(1);
                            state_q <= DEB_PRESS;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                    DEB_PRESS: begin
                        if (!same_row) begin
                            state_q <= SCAN;
                            col_q   <= col_q + 1'b1;
                        end else if (deb_last) begin
                            state_q   <= HELD;
                            key_q     <= code_of(row_q, col_q);
                            valid_q   <= 1'b1;
                            pressed_q <= 1'b1;
                            deb_q     <= '0;
                        end else begin
                            deb_q <= deb_q + 1'b1;
                        end
                    end
                    HELD: begin
                        if (!cand_low) begin
                            deb_q   <= DW'(1);
                            state_q <= DEB_REL;
                        end
                    end
                    DEB_REL: begin
                        if (cand_low) begin
                            state_q <= HELD;
                            deb_q   <= '0;
                        end else if (deb_last) begin
                            state_q   <= SCAN;
                            pressed_q <= 1'b0;
                            col_q     <= col_q + 1'b1;
                            deb_q     <= '0;
                        end else begin
                            deb_q <= deb_q + 1'b1;
                        end
                    end
                    default: state_q <= SCAN;
                endcase
            end
        end
    end

    assign kp.colN         = ~(4'b0001 << col_q);
    assign kp.keyPad       = key_q;
    assign kp.keyPadValid  = valid_q;
    assign kp.keyIsPressed = pressed_q;
endmodule
